// File: rtl/gaussian_blur_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gaussian_blur_stream_if                                         |
// | Purpose  : Row-input and pixel-output streams of gaussian_blur_stream.     |
// |            slave  = blur engine side, master = row source / pixel sink.    |
// | Signals  : row_valid/row_ready/row_data/row_first/row_last/mode_bypass     |
// |            out_valid/out_ready/out_data/out_eol/out_eof                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface gaussian_blur_stream_if #(
  parameter int PIX_W = 8,
  parameter int NOUT  = 16,
  parameter int LANES = 4
) ();
  localparam int NIN = NOUT + 4;

  logic                   row_valid;
  logic                   row_ready;
  logic [NIN*PIX_W-1:0]   row_data;
  logic                   row_first;
  logic                   row_last;
  logic                   mode_bypass;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*PIX_W-1:0] out_data;
  logic                   out_eol;
  logic                   out_eof;

  modport slave (
    input  row_valid, row_data, row_first, row_last, mode_bypass, out_ready,
    output row_ready, out_valid, out_data, out_eol, out_eof
  );

  modport master (
    output row_valid, row_data, row_first, row_last, mode_bypass, out_ready,
    input  row_ready, out_valid, out_data, out_eol, out_eof
  );
endinterface
`default_nettype wire

// File: rtl/gaussian_blur_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gaussian_blur_stream                                            |
// | Purpose  : Row-streaming 5x5 Gaussian blur (k = 1,4,8,4,1 separable).      |
// |            Holds a 5-row window over a frame, replicates border rows,      |
// |            flushes the bottom border automatically and emits LANES pixels  |
// |            per beat. Per-frame bypass passes the centre pixel through.     |
// | Ports    : clk   - clock                                                   |
// |            n_rst - synchronous active-low reset                            |
// |            bus   - slave side of gaussian_blur_stream_if (row in, pix out) |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gaussian_blur_stream #(
  parameter int PIX_W = 8,
  parameter int NOUT  = 16,   // must be a multiple of LANES
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  gaussian_blur_stream_if.slave bus
);
  localparam int NIN    = NOUT + 4;
  localparam int NBEATS = NOUT / LANES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SPAN   = LANES + 4;       // input columns touched by one beat
  localparam int SUM_W  = PIX_W + 9;       // kernel total 324 < 512
  localparam int PROD_W = SUM_W + 10;      // reciprocal 809 < 1024
  localparam int SHIFT  = 18;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [PROD_W-1:0] RECIP     = PROD_W'(809);     // ~2^18/324
  localparam logic [PROD_W-1:0] ROUND     = PROD_W'(131072);  // 0.5 LSB after shift

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                 state_q;
  logic [15:0]            rows_in_q;
  logic [15:0]            rows_out_q;
  logic                   frame_open_q;
  logic                   last_seen_q;
  logic                   bypass_q;
  logic [BEAT_W-1:0]      beat_q;
  logic                   load_done_q;   // final beat of the row already loaded
  logic                   row_ready_q;
  logic                   out_valid_q;
  logic [LANES*PIX_W-1:0] out_data_q;
  logic                   out_eol_q;
  logic                   out_eof_q;

  logic [NIN*PIX_W-1:0]   win_q [5];

  // ------------------------------------------------------------------------
  // Handshake decode
  // ------------------------------------------------------------------------
  logic        accept_w;
  logic        first_acc_w;
  logic        shift_acc_w;
  logic        last_new_w;
  logic        load_w;
  logic        row_done_w;
  logic [15:0] rows_in_inc_w;
  logic [15:0] rows_out_inc_w;

  assign bus.row_ready  = row_ready_q & n_rst;
  assign accept_w       = bus.row_valid & bus.row_ready;
  assign first_acc_w    = accept_w & bus.row_first;
  // Rows outside an open frame are silently dropped.
  assign shift_acc_w    = accept_w & ~bus.row_first & frame_open_q;
  assign last_new_w     = last_seen_q | bus.row_last;
  assign rows_in_inc_w  = rows_in_q + 16'd1;
  assign rows_out_inc_w = rows_out_q + 16'd1;
  // Output register refills whenever it is empty or being drained.
  assign load_w     = (state_q == EMIT) & ~load_done_q & (~out_valid_q | bus.out_ready);
  assign row_done_w = (state_q == EMIT) & load_done_q & out_valid_q & bus.out_ready;

  // ------------------------------------------------------------------------
  // Row window (datapath only, no reset needed: frame start overwrites it)
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (first_acc_w) begin
      for (int r = 0; r < 5; r++) win_q[r] <= bus.row_data;
    end else if (shift_acc_w) begin
      for (int r = 0; r < 4; r++) win_q[r] <= win_q[r+1];
      win_q[4] <= bus.row_data;
    end else if (state_q == FLUSH) begin
      // Bottom border: the last row is replicated into slot 4.
      for (int r = 0; r < 4; r++) win_q[r] <= win_q[r+1];
    end
  end

  // ------------------------------------------------------------------------
  // Beat datapath: vertical pass per column, then horizontal pass per lane
  // ------------------------------------------------------------------------
  function automatic logic [SUM_W-1:0] ktap(input int i);
    case (i)
      0, 4:    ktap = SUM_W'(1);
      1, 3:    ktap = SUM_W'(4);
      default: ktap = SUM_W'(8);
    endcase
  endfunction

  logic [PIX_W-1:0]       pix_w  [5][SPAN];
  logic [SUM_W-1:0]       vsum_w [SPAN];
  logic [SUM_W-1:0]       hsum_w [LANES];
  logic [PROD_W-1:0]      prod_w [LANES];
  logic [LANES*PIX_W-1:0] beat_data_w;

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < SPAN; j++) begin
        pix_w[r][j] = win_q[r][(int'(beat_q) * LANES + j) * PIX_W +: PIX_W];
      end
    end
    for (int j = 0; j < SPAN; j++) begin
      vsum_w[j] = '0;
      for (int r = 0; r < 5; r++) begin
        vsum_w[j] = vsum_w[j] + ktap(r) * SUM_W'(pix_w[r][j]);
      end
    end
    beat_data_w = '0;
    for (int l = 0; l < LANES; l++) begin
      hsum_w[l] = '0;
      for (int c = 0; c < 5; c++) begin
        hsum_w[l] = hsum_w[l] + ktap(c) * vsum_w[l+c];
      end
      // Divide by 324 as a multiply by 809/2^18 with round-half-up.
      prod_w[l] = PROD_W'(hsum_w[l]) * RECIP + ROUND;
      beat_data_w[l*PIX_W +: PIX_W] = bypass_q ? pix_w[2][l+2]
                                               : prod_w[l][SHIFT +: PIX_W];
    end
  end

  // ------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      rows_in_q    <= '0;
      rows_out_q   <= '0;
      frame_open_q <= 1'b0;
      last_seen_q  <= 1'b0;
      bypass_q     <= 1'b0;
      beat_q       <= '0;
      load_done_q  <= 1'b0;
      row_ready_q  <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_eol_q    <= 1'b0;
      out_eof_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (first_acc_w) begin
            // Also abandons any frame still open.
            rows_in_q    <= 16'd1;
            rows_out_q   <= '0;
            frame_open_q <= 1'b1;
            bypass_q     <= bus.mode_bypass;
            last_seen_q  <= bus.row_last;
            if (bus.row_last) begin
              state_q     <= FLUSH;
              row_ready_q <= 1'b0;
            end
          end else if (shift_acc_w) begin
            rows_in_q   <= rows_in_inc_w;
            last_seen_q <= last_new_w;
            if (rows_in_inc_w >= 16'd3) begin
              state_q     <= EMIT;
              row_ready_q <= 1'b0;
              beat_q      <= '0;
              load_done_q <= 1'b0;
            end else if (last_new_w) begin
              state_q     <= FLUSH;
              row_ready_q <= 1'b0;
            end
          end
        end

        FLUSH: begin
          state_q     <= EMIT;
          beat_q      <= '0;
          load_done_q <= 1'b0;
        end

        EMIT: begin
          if (load_w) begin
            out_valid_q <= 1'b1;
            out_data_q  <= beat_data_w;
            out_eol_q   <= (beat_q == LAST_BEAT);
            out_eof_q   <= (beat_q == LAST_BEAT) & last_seen_q &
                           (rows_out_inc_w == rows_in_q);
            if (beat_q == LAST_BEAT) load_done_q <= 1'b1;
            else                     beat_q      <= beat_q + BEAT_W'(1);
          end else if (row_done_w) begin
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            rows_out_q  <= rows_out_inc_w;
            if (last_seen_q && (rows_out_inc_w < rows_in_q)) begin
              state_q <= FLUSH;
            end else begin
              state_q     <= IDLE;
              row_ready_q <= 1'b1;
              if (last_seen_q) frame_open_q <= 1'b0;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          row_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_eol   = out_eol_q;
  assign bus.out_eof   = out_eof_q;

endmodule
`default_nettype wire

// File: tb/tb_gaussian_blur_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gaussian_blur_stream                                         |
// | Purpose  : Self-checking bench for gaussian_blur_stream. Expected beats    |
// |            come from a clamp-at-border reference blur and are queued when  |
// |            a frame is driven, then popped as the DUT emits.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_gaussian_blur_stream;
  localparam int PIX_W = 8;
  localparam int NOUT  = 16;
  localparam int LANES = 4;
  localparam int NIN   = NOUT + 4;
  localparam int NB    = NOUT / LANES;
  localparam int MAXH  = 8;

  typedef struct packed {
    logic [LANES*PIX_W-1:0] data;
    logic                   eol;
    logic                   eof;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  gaussian_blur_stream_if #(.PIX_W(PIX_W), .NOUT(NOUT), .LANES(LANES)) bus_if ();

  gaussian_blur_stream #(.PIX_W(PIX_W), .NOUT(NOUT), .LANES(LANES)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus_if)
  );

  int               n_checks = 0;
  int               n_pass   = 0;
  int               cyc      = 0;
  int               beats_seen = 0;
  int               acc_cyc  = 0;
  logic [PIX_W-1:0] img [MAXH][NIN];
  exp_t             sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: blur with explicit row clamping at the frame borders.
  function automatic int kk(input int i);
    if (i == 0 || i == 4) return 1;
    if (i == 1 || i == 3) return 4;
    return 8;
  endfunction

  function automatic logic [PIX_W-1:0] ref_pix(input int y, input int c, input int h, input bit byp);
    int s;
    int yy;
    longint p;
    if (byp) return img[y][c+2];
    s = 0;
    for (int dr = -2; dr <= 2; dr++) begin
      yy = y + dr;
      if (yy < 0) yy = 0;
      if (yy > h - 1) yy = h - 1;
      for (int dc = 0; dc < 5; dc++) s += kk(dr + 2) * kk(dc) * int'(img[yy][c+dc]);
    end
    p = (longint'(s) * 809 + 131072) >>> 18;
    return p[PIX_W-1:0];
  endfunction

  task automatic push_frame(input int h, input bit byp);
    exp_t e;
    for (int y = 0; y < h; y++) begin
      for (int b = 0; b < NB; b++) begin
        for (int l = 0; l < LANES; l++) e.data[l*PIX_W +: PIX_W] = ref_pix(y, b*LANES + l, h, byp);
        e.eol = (b == NB - 1);
        e.eof = (b == NB - 1) && (y == h - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_row(input int y, input bit first, input bit last, input bit byp);
    bit done;
    for (int i = 0; i < NIN; i++) bus_if.row_data[i*PIX_W +: PIX_W] = img[y][i];
    bus_if.row_first   = first;
    bus_if.row_last    = last;
    bus_if.mode_bypass = byp;
    bus_if.row_valid   = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (bus_if.row_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
    end
    check("row_accepted", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    bus_if.row_valid = 1'b0;
    bus_if.row_first = 1'b0;
    bus_if.row_last  = 1'b0;
  endtask

  task automatic send_frame(input int h, input bit byp);
    push_frame(h, byp);
    for (int y = 0; y < h; y++) send_row(y, y == 0, y == h - 1, byp);
  endtask

  task automatic wait_drain(input int base, input int nbeats);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("beat_count", 64'(beats_seen - base), 64'(nbeats));
  endtask

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (n_rst === 1'b1 && bus_if.out_valid === 1'b1) begin
      check("row_ready_while_out", 64'(bus_if.row_ready), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(bus_if.out_valid), 64'd0);
      end else begin
        // Also applies on stalled cycles, so held data must stay correct.
        check("out_data", 64'(bus_if.out_data), 64'(sb[0].data));
        check("out_eol", 64'(bus_if.out_eol), 64'(sb[0].eol));
        check("out_eof", 64'(bus_if.out_eof), 64'(sb[0].eof));
        if (bus_if.out_ready) begin
          void'(sb.pop_front());
          beats_seen++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int t2;

    n_rst              = 1'b0;
    bus_if.row_valid   = 1'b0;
    bus_if.row_data    = '0;
    bus_if.row_first   = 1'b0;
    bus_if.row_last    = 1'b0;
    bus_if.mode_bypass = 1'b0;
    bus_if.out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_row_ready", 64'(bus_if.row_ready), 64'd0);
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_out_data", 64'(bus_if.out_data), 64'd0);
    check("rst_out_eol", 64'(bus_if.out_eol), 64'd0);
    check("rst_out_eof", 64'(bus_if.out_eof), 64'd0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check("idle_row_ready", 64'(bus_if.row_ready), 64'd1);

    // Constant frame H=4 with latency and row-period checks
    for (int y = 0; y < 4; y++) for (int i = 0; i < NIN; i++) img[y][i] = 8'd100;
    base = beats_seen;
    push_frame(4, 1'b0);
    send_row(0, 1'b1, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0, 1'b0);
    send_row(2, 1'b0, 1'b0, 1'b0);
    t2 = acc_cyc;
    check("ready_low_after_accept", 64'(bus_if.row_ready), 64'd0);
    @(negedge clk);
    check("valid_t1", 64'(bus_if.out_valid), 64'd0);
    @(negedge clk);
    check("valid_t2", 64'(bus_if.out_valid), 64'd1);
    send_row(3, 1'b0, 1'b1, 1'b0);
    check("row_period", 64'(acc_cyc - t2), 64'(NB + 2));
    wait_drain(base, 4 * NB);

    // Impulse H=5
    for (int y = 0; y < 5; y++) for (int i = 0; i < NIN; i++) img[y][i] = '0;
    img[2][10] = 8'd255;
    base = beats_seen;
    send_frame(5, 1'b0);
    wait_drain(base, 5 * NB);

    // H=1
    for (int i = 0; i < NIN; i++) img[0][i] = 8'd7;
    base = beats_seen;
    send_frame(1, 1'b0);
    wait_drain(base, NB);

    // H=2, rows of 0 and 255
    for (int i = 0; i < NIN; i++) begin
      img[0][i] = 8'd0;
      img[1][i] = 8'd255;
    end
    base = beats_seen;
    send_frame(2, 1'b0);
    wait_drain(base, 2 * NB);

    // Backpressure: 5 stalled cycles, then ready toggling
    for (int y = 0; y < 3; y++) for (int i = 0; i < NIN; i++) img[y][i] = PIX_W'($urandom_range(0, 255));
    base = beats_seen;
    fork
      send_frame(3, 1'b0);
      begin
        int k;
        k = 0;
        while (beats_seen < base + 2 && k < 500) begin
          @(posedge clk);
          k++;
        end
        #1 bus_if.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        for (int i = 0; i < 40; i++) begin
          #1 bus_if.out_ready = ~bus_if.out_ready;
          @(posedge clk);
        end
        #1 bus_if.out_ready = 1'b1;
      end
    join
    wait_drain(base, 3 * NB);

    // Bypass, pixel i = 10*i
    for (int y = 0; y < 3; y++) for (int i = 0; i < NIN; i++) img[y][i] = PIX_W'(10 * i);
    base = beats_seen;
    send_frame(3, 1'b1);
    wait_drain(base, 3 * NB);

    // Reset during beat 2 of the first emitted row
    for (int y = 0; y < 5; y++) for (int i = 0; i < NIN; i++) img[y][i] = PIX_W'($urandom_range(0, 255));
    push_frame(5, 1'b0);
    send_row(0, 1'b1, 1'b0, 1'b0);
    send_row(1, 1'b0, 1'b0, 1'b0);
    send_row(2, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("beat2_valid", 64'(bus_if.out_valid), 64'd1);
    n_rst = 1'b0;
    bus_if.out_ready = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    n_rst = 1'b1;
    bus_if.out_ready = 1'b1;
    check("valid_after_reset", 64'(bus_if.out_valid), 64'd0);
    check("eol_after_reset", 64'(bus_if.out_eol), 64'd0);
    check("data_after_reset", 64'(bus_if.out_data), 64'd0);

    // Row without row_first after reset is dropped
    base = beats_seen;
    send_row(0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("dropped_row_beats", 64'(beats_seen - base), 64'd0);
    check("dropped_row_ready", 64'(bus_if.row_ready), 64'd1);

    // Fresh frame completes normally
    base = beats_seen;
    send_frame(3, 1'b0);
    wait_drain(base, 3 * NB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
